// File: rtl/regfile_port_arbiter.sv
// Two-requester round-robin arbiter feeding a one-deep register-file issue stage.
// Writes commit at the edge after they are presented; reads return two cycles after grant.
module regfile_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] dst0,
  input  logic [ADDR_W-1:0] dst1,
  input  logic [ADDR_W-1:0] src0,
  input  logic [ADDR_W-1:0] src1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] dstRdata,
  output logic [DATA_W-1:0] srcRdata,
  output logic              rf_writeEnable,
  output logic [ADDR_W-1:0] rf_dst,
  output logic [ADDR_W-1:0] rf_src,
  output logic [DATA_W-1:0] rf_dstWrite,
  input  logic [DATA_W-1:0] rf_dstRead,
  input  logic [DATA_W-1:0] rf_srcRead
);

  // state | meaning
  // IDLE  | nothing presented to the register file
  // WR    | write presented; register file commits at the next edge
  // RD    | read presented; read data captured and rvalid pulsed at the next edge
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t state, stateNext;
  logic   favour1;
  logic   owner;
  logic   gntIdx;
  logic   gntWe;

  // The stage is always free, so grant is a pure function of req and the pointer.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = favour1 ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    gntIdx    = gnt[1];
    gntWe     = we[gntIdx];
    stateNext = IDLE;
    if (|gnt) stateNext = gntWe ? WR : RD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  assign rf_writeEnable = (state == WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      favour1     <= 1'b0;
      owner       <= 1'b0;
      rf_dst      <= '0;
      rf_src      <= '0;
      rf_dstWrite <= '0;
      rvalid      <= 2'b00;
      dstRdata    <= '0;
      srcRdata    <= '0;
    end else begin
      if (|gnt) begin
        favour1 <= ~gntIdx;
        owner   <= gntIdx;
        rf_dst  <= gntIdx ? dst1 : dst0;
        if (gntWe) rf_dstWrite <= gntIdx ? wdata1 : wdata0;
        else       rf_src      <= gntIdx ? src1 : src0;
      end
      rvalid <= 2'b00;
      if (state == RD) begin
        rvalid   <= owner ? 2'b10 : 2'b01;
        dstRdata <= rf_dstRead;
        srcRdata <= rf_srcRead;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: behavioural register-file model plus an
// event-scheduled reference (grant cycle, write at +1, read return at +2).
module tb_regfile_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = '0, we = '0;
  logic [AW-1:0] dst0 = '0, dst1 = '0, src0 = '0, src1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] dstRdata, srcRdata, rf_dstWrite, rf_dstRead, rf_srcRead;
  logic          rf_writeEnable;
  logic [AW-1:0] rf_dst, rf_src;

  logic [DW-1:0] tbRf [16] = '{default: '0};

  regfile_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .dst0(dst0), .dst1(dst1), .src0(src0), .src1(src1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .dstRdata(dstRdata), .srcRdata(srcRdata),
    .rf_writeEnable(rf_writeEnable), .rf_dst(rf_dst), .rf_src(rf_src),
    .rf_dstWrite(rf_dstWrite), .rf_dstRead(rf_dstRead), .rf_srcRead(rf_srcRead)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_writeEnable) tbRf[rf_dst] <= rf_dstWrite;
  assign rf_dstRead = tbRf[rf_dst];
  assign rf_srcRead = tbRf[rf_src];

  // Reference model: expected register contents and per-cycle scheduled events.
  logic [DW-1:0] refMem [16];
  bit            favour1;
  int            cyc;
  logic [AW-1:0] wrDst [int];
  logic [DW-1:0] wrData [int];
  logic [1:0]    rdOwner [int];
  logic [AW-1:0] rdDst [int];
  logic [AW-1:0] rdSrc [int];
  logic [DW-1:0] lastD, lastS;
  int            passed = 0, total = 0;

  function automatic logic [1:0] modelGrant();
    if (!rst_n) return 2'b00;
    case (req)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return favour1 ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [200:0] expVec();
    logic [1:0]    rv = 2'b00;
    logic [DW-1:0] d = lastD, s = lastS, wdat = '0;
    logic          w = 1'b0;
    logic [AW-1:0] wd = '0;
    if (rdOwner.exists(cyc)) begin
      rv = rdOwner[cyc]; d = refMem[rdDst[cyc]]; s = refMem[rdSrc[cyc]];
    end
    if (wrDst.exists(cyc)) begin
      w = 1'b1; wd = wrDst[cyc]; wdat = wrData[cyc];
    end
    return {modelGrant(), w, wd, wdat, rv, d, s};
  endfunction

  function automatic logic [200:0] obsVec();
    return {gnt, rf_writeEnable, rf_writeEnable ? rf_dst : 4'h0,
            rf_writeEnable ? rf_dstWrite : 64'h0, rvalid, dstRdata, srcRdata};
  endfunction

  task automatic modelReset();
    wrDst.delete(); wrData.delete(); rdOwner.delete(); rdDst.delete(); rdSrc.delete();
    favour1 = 1'b0; lastD = '0; lastS = '0;
  endtask

  task automatic modelAccept();
    logic [1:0] g = modelGrant();
    if (g != 2'b00) begin
      int i = g[1] ? 1 : 0;
      favour1 = (i == 0);
      if (we[i]) begin
        wrDst[cyc+1]  = i ? dst1 : dst0;
        wrData[cyc+1] = i ? wdata1 : wdata0;
      end else begin
        rdOwner[cyc+2] = g;
        rdDst[cyc+2]   = i ? dst1 : dst0;
        rdSrc[cyc+2]   = i ? src1 : src0;
      end
    end
  endtask

  // Closes the current cycle: read return observed, then pending write commits.
  task automatic advance();
    modelAccept();
    if (rdOwner.exists(cyc)) begin
      lastD = refMem[rdDst[cyc]]; lastS = refMem[rdSrc[cyc]];
    end
    if (rst_n && wrDst.exists(cyc)) refMem[wrDst[cyc]] = wrData[cyc];
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [3:0] d0,
                       input logic [3:0] s0, input logic [3:0] d1, input logic [3:0] s1,
                       input logic [63:0] w0, input logic [63:0] w1);
    req = r; we = w; dst0 = d0; src0 = s0; dst1 = d1; src1 = s1; wdata0 = w0; wdata1 = w1;
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b11, 4'd1, 4'd2, 4'd3, 4'd4, 64'h1, 64'h2);
    repeat (2) @(posedge clk);
    #1;
    if (gnt !== 2'b00) $display("FAIL reset_gnt got %b want 00", gnt); else passed++;
    total++;
    if ({rf_writeEnable, rvalid, rf_dst, rf_src, rf_dstWrite, dstRdata, srcRdata} !== '0)
      $display("FAIL reset_outputs got we=%b rv=%b dst=%h src=%h wd=%h d=%h s=%h want all 0",
               rf_writeEnable, rvalid, rf_dst, rf_src, rf_dstWrite, dstRdata, srcRdata);
    else passed++;
    total++;
    rst_n = 1'b1;
    modelReset();
    cyc = 0;
    drive(2'b11, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    #1;
    if (gnt !== 2'b01) $display("FAIL reset_first_grant got %b want 01", gnt); else passed++;
    total++;
    advance();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    repeat (3) begin
      #1;
      if (obsVec() !== expVec()) $display("FAIL reset_drain c=%0d got %h want %h", cyc, obsVec(), expVec());
      else passed++;
      total++;
      advance();
    end
  endtask

  task automatic test_single_write();
    drive(2'b01, 2'b01, 4'd3, 4'd0, 4'd0, 4'd0, 64'hA5A5_0000_1234_5678, 64'h0);
    #1;
    if (gnt !== 2'b01) $display("FAIL single_write_gnt got %b want 01", gnt); else passed++;
    total++;
    advance();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    #1;
    if ({rf_writeEnable, rf_dst, rf_dstWrite} !== {1'b1, 4'd3, 64'hA5A5_0000_1234_5678})
      $display("FAIL single_write_issue got we=%b dst=%0d wd=%h want we=1 dst=3 wd=a5a5000012345678",
               rf_writeEnable, rf_dst, rf_dstWrite);
    else passed++;
    total++;
    advance();
    #1;
    if (rf_writeEnable !== 1'b0) $display("FAIL single_write_len got we=%b want 0", rf_writeEnable);
    else passed++;
    total++;
    advance();
  endtask

  task automatic test_write_then_read();
    logic [1:0] r [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
    logic [1:0] w [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
    for (int k = 0; k < 4; k++) begin
      drive(r[k], w[k], 4'd7, 4'd7, 4'd0, 4'd0, 64'hDEAD_BEEF_0000_0001, 64'h0);
      #1;
      if (obsVec() !== expVec()) $display("FAIL wr_rd c=%0d got %h want %h", cyc, obsVec(), expVec());
      else passed++;
      total++;
      if (k == 3) begin
        if ({rvalid, dstRdata, srcRdata} !== {2'b01, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001})
          $display("FAIL wr_rd_return got rv=%b d=%h s=%h want rv=01 d=s=deadbeef00000001",
                   rvalid, dstRdata, srcRdata);
        else passed++;
        total++;
      end
      advance();
    end
  endtask

  task automatic test_contention();
    logic [1:0] expG [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    rst_n = 1'b0;
    modelReset();
    advance();
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(2'b11, 2'b01, 4'd9, 4'd0, 4'd9, 4'd9, {$urandom, $urandom}, 64'h0);
      else       drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
      #1;
      if (k < 4) begin
        if (gnt !== expG[k]) $display("FAIL contention_gnt k=%0d got %b want %b", k, gnt, expG[k]);
        else passed++;
        total++;
      end
      if (obsVec() !== expVec()) $display("FAIL contention c=%0d got %h want %h", cyc, obsVec(), expVec());
      else passed++;
      total++;
      advance();
    end
  endtask

  task automatic test_sweep();
    for (int r = 0; r < 16; r++) begin
      for (int ph = 0; ph < 2; ph++) begin
        logic [1:0] who = ((r + ph) % 2 == 0) ? 2'b01 : 2'b10;
        logic [63:0] dat = {$urandom, $urandom};
        drive(who, ph == 0 ? who : 2'b00, 4'(r), 4'(r), 4'(r), 4'(r), dat, dat);
        #1;
        if (obsVec() !== expVec()) $display("FAIL sweep c=%0d got %h want %h", cyc, obsVec(), expVec());
        else passed++;
        total++;
        advance();
      end
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    repeat (2) begin
      #1;
      if (obsVec() !== expVec()) $display("FAIL sweep_tail c=%0d got %h want %h", cyc, obsVec(), expVec());
      else passed++;
      total++;
      advance();
    end
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] oldV = {$urandom, $urandom};
    logic [63:0] newV = ~oldV;
    drive(2'b01, 2'b01, 4'd5, 4'd0, 4'd0, 4'd0, oldV, 64'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (obsVec() !== expVec()) $display("FAIL midrst_pre c=%0d got %h want %h", cyc, obsVec(), expVec());
      else passed++;
      total++;
      advance();
      drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    end
    drive(2'b01, 2'b01, 4'd5, 4'd0, 4'd0, 4'd0, newV, 64'h0);
    #1;
    advance();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    #1;
    if (rf_writeEnable !== 1'b1) $display("FAIL midrst_we_before got %b want 1", rf_writeEnable);
    else passed++;
    total++;
    rst_n = 1'b0;
    #1;
    if (rf_writeEnable !== 1'b0) $display("FAIL midrst_async_drop got %b want 0", rf_writeEnable);
    else passed++;
    total++;
    modelReset();
    advance();
    rst_n = 1'b1;
    drive(2'b10, 2'b00, 4'd0, 4'd0, 4'd5, 4'd5, 64'h0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (obsVec() !== expVec()) $display("FAIL midrst_read c=%0d got %h want %h", cyc, obsVec(), expVec());
      else passed++;
      total++;
      if (k == 2) begin
        if ({rvalid, dstRdata} !== {2'b10, oldV})
          $display("FAIL midrst_prior_value got rv=%b d=%h want rv=10 d=%h", rvalid, dstRdata, oldV);
        else passed++;
        total++;
      end
      advance();
      drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    end
  endtask

  task automatic test_idle();
    drive(2'b01, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    #1;
    advance();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    repeat (2) begin
      #1;
      advance();
    end
    for (int k = 0; k < 10; k++) begin
      #1;
      if ({gnt, rvalid, rf_writeEnable} !== 5'b0)
        $display("FAIL idle k=%0d got gnt=%b rv=%b we=%b want 0", k, gnt, rvalid, rf_writeEnable);
      else passed++;
      total++;
      advance();
    end
    drive(2'b11, 2'b00, 4'd1, 4'd1, 4'd1, 4'd1, 64'h0, 64'h0);
    #1;
    if (gnt !== 2'b10) $display("FAIL idle_pointer got %b want 10", gnt); else passed++;
    total++;
    advance();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    repeat (2) begin
      #1;
      if (obsVec() !== expVec()) $display("FAIL idle_drain c=%0d got %h want %h", cyc, obsVec(), expVec());
      else passed++;
      total++;
      advance();
    end
  endtask

  task automatic test_random();
    logic [1:0]    pend = 2'b00;
    logic          pWe [2];
    logic [AW-1:0] pDst [2], pSrc [2];
    logic [DW-1:0] pDat [2];
    int            waitCnt [2] = '{0, 0};
    for (int n = 0; n < 400; n++) begin
      logic [1:0] g;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i] = 1'b1;
          pWe[i]  = 1'($urandom_range(0, 1));
          pDst[i] = 4'($urandom);
          pSrc[i] = 4'($urandom);
          pDat[i] = {$urandom, $urandom};
        end
      end
      drive(pend, {pWe[1], pWe[0]}, pDst[0], pSrc[0], pDst[1], pSrc[1], pDat[0], pDat[1]);
      #1;
      if (obsVec() !== expVec()) $display("FAIL random c=%0d got %h want %h", cyc, obsVec(), expVec());
      else passed++;
      total++;
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          waitCnt[i] = gnt[i] ? 0 : waitCnt[i] + 1;
          if (waitCnt[i] > 1) $display("FAIL random_wait req%0d c=%0d got wait=%0d want <=1", i, cyc, waitCnt[i]);
          else passed++;
          total++;
        end
      end
      g = modelGrant();
      advance();
      pend = pend & ~g;
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0);
    repeat (3) begin
      #1;
      if (obsVec() !== expVec()) $display("FAIL random_tail c=%0d got %h want %h", cyc, obsVec(), expVec());
      else passed++;
      total++;
      advance();
    end
  endtask

  initial begin
    foreach (refMem[i]) refMem[i] = '0;
    cyc = 0;
    modelReset();
    test_reset();
    test_single_write();
    test_write_then_read();
    test_contention();
    test_sweep();
    test_reset_mid_write();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
